// File: rtl/dmem_responder.sv
// Responder end of the core data-memory port: SRAM below MMIO_BASE, a small
// SCRATCH/CYCLE/TOHOST register block at and above it, with LATENCY wait states.
module dmem_responder #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h4000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmem_rd_i,
  input  logic                  dmem_wr_i,
  input  logic [3:0]            dmem_strobe_i,
  input  logic [31:0]           dmem_addr_i,
  input  logic [31:0]           dmem_wdata_i,
  output logic                  dmem_ready_o,
  output logic                  dmem_rdata_valid_o,
  output logic [31:0]           dmem_rdata_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_strobe_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [31:0]           tohost_o,
  output logic                  halt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_rd_q, is_rd_d;
  logic        mem_phase_q, mem_phase_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tohost_q, tohost_d;

  logic        ready_s, valid_s, accept_s, rd_only_s, mmio_s;
  logic [31:0] off_s, mmio_rdata_s, resp_data_s;
  logic [29:0] off_word_s;

  assign accept_s   = ready_s & (dmem_rd_i | dmem_wr_i);
  assign rd_only_s  = dmem_rd_i & ~dmem_wr_i;
  assign mmio_s     = (dmem_addr_i >= MMIO_BASE);
  assign off_s      = dmem_addr_i - MMIO_BASE;
  assign off_word_s = 30'(off_s >> 2);

  // MMIO read mux, evaluated at the accept cycle
  always_comb begin
    mmio_rdata_s = 32'd0;
    case (off_word_s)
      30'd0:   mmio_rdata_s = scratch_q;
      30'd1:   mmio_rdata_s = cycle_q;
      30'd2:   mmio_rdata_s = tohost_q;
      default: mmio_rdata_s = 32'd0;
    endcase
  end

  // Handshake FSM: next state, wait counter and response type
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    ready_s = 1'b0;
    valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        ready_s = 1'b1;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        ready_s = 1'b1;
        valid_s = is_rd_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept_s) begin
      is_rd_d = rd_only_s;
      if (LAT_CNT == 4'd1) begin
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = LAT_CNT - 4'd1;
      end
    end else begin
      is_rd_d = is_rd_q;
    end
  end

  // Register block updates and read-data staging
  always_comb begin
    scratch_d   = scratch_q;
    tohost_d    = tohost_q;
    cycle_d     = cycle_q + 32'd1;
    hold_d      = hold_q;
    mem_phase_d = accept_s & ~mmio_s & rd_only_s;
    if (accept_s && mmio_s && dmem_wr_i) begin
      case (off_word_s)
        30'd0:   scratch_d = merge_bytes(scratch_q, dmem_wdata_i, dmem_strobe_i);
        30'd2:   tohost_d  = merge_bytes(tohost_q, dmem_wdata_i, dmem_strobe_i);
        default: scratch_d = scratch_q;
      endcase
    end else begin
      scratch_d = scratch_q;
    end
    // A new MMIO read can only collide with a capture when LATENCY is 1, where
    // the captured word is being forwarded straight from mem_rdata_i anyway.
    if (accept_s && mmio_s && rd_only_s) begin
      hold_d = mmio_rdata_s;
    end else if (mem_phase_q) begin
      hold_d = mem_rdata_i;
    end else begin
      hold_d = hold_q;
    end
    resp_data_s = mem_phase_q ? mem_rdata_i : hold_q;
    rdata_d     = valid_s ? resp_data_s : rdata_q;
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      is_rd_q     <= 1'b0;
      mem_phase_q <= 1'b0;
      hold_q      <= 32'd0;
      rdata_q     <= 32'd0;
      scratch_q   <= 32'd0;
      cycle_q     <= 32'd0;
      tohost_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_rd_q     <= is_rd_d;
      mem_phase_q <= mem_phase_d;
      hold_q      <= hold_d;
      rdata_q     <= rdata_d;
      scratch_q   <= scratch_d;
      cycle_q     <= cycle_d;
      tohost_q    <= tohost_d;
    end
  end

  assign dmem_ready_o       = ready_s;
  assign dmem_rdata_valid_o = valid_s;
  assign dmem_rdata_o       = valid_s ? resp_data_s : rdata_q;
  assign mem_en_o           = accept_s & ~mmio_s;
  assign mem_strobe_o       = (accept_s && !mmio_s && dmem_wr_i) ? dmem_strobe_i : 4'd0;
  assign mem_addr_o         = dmem_addr_i[ADDR_WIDTH+1:2];
  assign mem_wdata_o        = dmem_wdata_i;
  assign tohost_o           = tohost_q;
  assign halt_o             = tohost_q[0];

endmodule
